wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
- Write-side pointer and flag generator for the async FIFO; sits directly upstream of the dual-clock FIFO memory in the w_clk domain.
- Counts accepted writes and drives the memory write address.
- Brings the read-domain Gray pointer into w_clk through a 2-flop synchronizer.
- Produces the wfull, hfull, occupancy and overflow indications that gate the memory write enable.

Parameters:
- A_Size, 8, address width. FIFO depth = 2**A_Size. Pointers are A_Size+1 bits.
- HALF_TH, 2**(A_Size-1), occupancy at or above which hfull asserts.

Ports:
- w_clk  input  1  write-domain clock; all state is clocked on the rising edge.
- w_rst  input  1  asynchronous reset, active-low. Asserted (0) clears all state immediately.
- w_inc  input  1  write request from the producer.
- r_ptr_gray  input  A_Size+1  Gray read pointer from the read domain. It is asynchronous to w_clk.
- waddr  output  A_Size+1  binary write pointer. The memory indexes waddr[A_Size-1:0].
- w_ptr_gray  output  A_Size+1  registered Gray write pointer, sent to the read domain.
- wfull  output  1  FIFO full.
- hfull  output  1  occupancy >= HALF_TH.
- wcount  output  A_Size+1  write-side occupancy, range 0..2**A_Size.
- wovf  output  1  sticky overflow: a write was attempted while full.

Behaviour:
- Reset (w_rst=0, async): waddr=0, w_ptr_gray=0, both sync flops rq1/rq2=0, wfull=0, hfull=0, wcount=0, wovf=0.
  - Takes effect at once, mid-operation included.
  - Release is sampled on the next w_clk edge.
- Accept condition: wr_ok = w_inc & !wfull. This is the same term the memory uses as its write enable, so memory and pointer stay in lockstep.
- Pointer update:
  - wbin_next = waddr + wr_ok, wrapping modulo 2**(A_Size+1). The MSB is the wrap bit.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Both are registered. waddr and w_ptr_gray change on the edge that accepts the write.
  - Exactly one bit of w_ptr_gray changes per accepted write.
- Synchronizer: rq1 <= r_ptr_gray; rq2 <= rq1. No other logic may sample r_ptr_gray.
- rbin_sync = Gray-to-binary(rq2), combinational: bit i = XOR of rq2[A_Size:i].
- Full flag (registered): wfull <= (wgray_next == {~rq2[A_Size:A_Size-1], rq2[A_Size-2:0]}).
- Occupancy (registered): wcount <= (wbin_next - rbin_sync) mod 2**(A_Size+1). It never exceeds 2**A_Size.
- Half flag (registered): hfull <= ((wbin_next - rbin_sync) >= HALF_TH).
- Overflow: wovf <= wovf | (w_inc & wfull). It is cleared only by reset.
- Write while full: the write is dropped, waddr and w_ptr_gray hold, and wovf sets on that edge.
- Flags are pessimistic:
  - A read-pointer change reaches wfull, hfull and wcount on the 3rd w_clk edge after r_ptr_gray is stable (edge 1 rq1, edge 2 rq2, edge 3 flags).
  - A write affects the flags on the same edge it is accepted.
- Write on the edge where a pending read frees space: while wfull is still 1 the write is rejected. No look-ahead.
- Wrap-around: after 2**(A_Size+1) accepted writes waddr returns to 0, and full/empty decoding stays correct through the MSB.
- r_ptr_gray may move by several Gray steps between samples. The flags must remain conservative: never report less full than actual.

Test Plan (A_Size=4, depth 16, HALF_TH=8):
- Reset: hold w_rst=0 with w_inc=1 and r_ptr_gray=5'b00110 -> all outputs 0, waddr stays 0. Deassert reset -> waddr increments on the first edge.
- Fill: r_ptr_gray=0, 16 back-to-back w_inc.
  - Expect waddr=16 (5'b10000), w_ptr_gray=5'b11000, wcount=16, wfull=1 on the 16th edge.
  - hfull=1 from the 8th edge, wovf=0.
- Overflow: from full, pulse w_inc 3 cycles -> waddr holds 16, wovf=1 after the first attempt, and stays 1 until reset.
- Drain release: from full, set r_ptr_gray=gray(4)=5'b00110 -> wfull=0 and wcount=12 on the 3rd edge. hfull stays 1.
- Half boundary: wcount=8 with read pointer advancing by 1 -> hfull drops to 0 three edges later (wcount=7). One further write -> hfull=1 on that edge.
- Wrap: 40 writes interleaved with r_ptr_gray tracking (write ptr - 2) -> waddr wraps 31->0, wfull never asserts, wcount settles at 2, and each w_ptr_gray step changes exactly one bit.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, read-pointer synchronizer and full/half/occupancy/overflow
// flag generator for the w_clk domain of a dual-clock FIFO.
module wptr_full_ctrl #(
  parameter int A_Size  = 8,
  parameter int HALF_TH = 2**(A_Size-1)
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_inc,
  input  logic [A_Size:0]   r_ptr_gray,
  output logic [A_Size:0]   waddr,
  output logic [A_Size:0]   w_ptr_gray,
  output logic              wfull,
  output logic              hfull,
  output logic [A_Size:0]   wcount,
  output logic              wovf
);

  localparam int PW = A_Size + 1;

  logic [A_Size:0] waddr_q,  waddr_d;
  logic [A_Size:0] wgray_q,  wgray_d;
  logic [A_Size:0] rq1_q,    rq1_d;
  logic [A_Size:0] rq2_q,    rq2_d;
  logic            wfull_q,  wfull_d;
  logic            hfull_q,  hfull_d;
  logic [A_Size:0] wcount_q, wcount_d;
  logic            wovf_q,   wovf_d;

  logic            wr_ok;
  logic [A_Size:0] rbin_sync;
  logic [A_Size:0] occ;

  // Handshake: w_inc is a valid with no stall, !wfull acts as ready; a write
  // transfers on a rising edge where w_inc & !wfull, and the memory uses the
  // same wr_ok term as its write enable.
  always_comb begin
    wr_ok   = w_inc & ~wfull_q;
    waddr_d = waddr_q + {{A_Size{1'b0}}, wr_ok};
    wgray_d = (waddr_d >> 1) ^ waddr_d;

    rq1_d = r_ptr_gray;
    rq2_d = rq1_q;

    rbin_sync         = '0;
    rbin_sync[A_Size] = rq2_q[A_Size];
    for (int i = A_Size - 1; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ rq2_q[i];
    end

    // Stale synchronized read pointer can only overstate occupancy.
    occ      = waddr_d - rbin_sync;
    wcount_d = occ;
    hfull_d  = (occ >= PW'(HALF_TH));
    wfull_d  = (wgray_d == {~rq2_q[A_Size:A_Size-1], rq2_q[A_Size-2:0]});
    wovf_d   = wovf_q | (w_inc & wfull_q);
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      waddr_q  <= '0;
      wgray_q  <= '0;
      rq1_q    <= '0;
      rq2_q    <= '0;
      wfull_q  <= 1'b0;
      hfull_q  <= 1'b0;
      wcount_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      wgray_q  <= wgray_d;
      rq1_q    <= rq1_d;
      rq2_q    <= rq2_d;
      wfull_q  <= wfull_d;
      hfull_q  <= hfull_d;
      wcount_q <= wcount_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr      = waddr_q;
  assign w_ptr_gray = wgray_q;
  assign wfull      = wfull_q;
  assign hfull      = hfull_q;
  assign wcount     = wcount_q;
  assign wovf       = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl at A_Size=4: vector table for fill/overflow/drain/half,
// plus hand sequences for reset behaviour and pointer wrap-around.
module tb_wptr_full_ctrl;

  localparam int AW = 4;
  localparam int W  = 18;

  logic          w_clk;
  logic          w_rst;
  logic          w_inc;
  logic [AW:0]   r_ptr_gray;
  logic [AW:0]   waddr;
  logic [AW:0]   w_ptr_gray;
  logic          wfull;
  logic          hfull;
  logic [AW:0]   wcount;
  logic          wovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic       inc;
    logic [4:0] rg;
    logic [4:0] addr;
    logic       full;
    logic       half;
    logic [4:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  wptr_full_ctrl #(.A_Size(AW), .HALF_TH(8)) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_inc      (w_inc),
    .r_ptr_gray (r_ptr_gray),
    .waddr      (waddr),
    .w_ptr_gray (w_ptr_gray),
    .wfull      (wfull),
    .hfull      (hfull),
    .wcount     (wcount),
    .wovf       (wovf)
  );

  // clock / reset
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] pack(input logic [4:0] a, input logic f, input logic h,
                                        input logic [4:0] c, input logic o);
    return {a, gray5(a), f, h, c, o};
  endfunction

  function automatic vec_t mk(input logic inc, input logic [4:0] rg, input logic [4:0] a,
                              input logic f, input logic h, input logic [4:0] c, input logic o);
    vec_t v;
    v.inc = inc; v.rg = rg; v.addr = a; v.full = f; v.half = h; v.cnt = c; v.ovf = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_out(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_waddr"},  waddr,      e[17:13]);
    chk({tag, "_wgray"},  w_ptr_gray, e[12:8]);
    chk({tag, "_wfull"},  wfull,      e[7]);
    chk({tag, "_hfull"},  hfull,      e[6]);
    chk({tag, "_wcount"}, wcount,     e[5:1]);
    chk({tag, "_wovf"},   wovf,       e[0]);
  endtask

  // driver: called 1 time unit after a rising edge, samples 1 after the next
  task automatic apply(input string tag, input logic inc, input logic [4:0] rg, input logic [W-1:0] e);
    exp_q.push_back(e);
    w_inc      = inc;
    r_ptr_gray = rg;
    @(posedge w_clk);
    #1;
    compare_out(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_waddr"},  waddr,      0);
    chk({tag, "_wgray"},  w_ptr_gray, 0);
    chk({tag, "_wfull"},  wfull,      0);
    chk({tag, "_hfull"},  hfull,      0);
    chk({tag, "_wcount"}, wcount,     0);
    chk({tag, "_wovf"},   wovf,       0);
  endtask

  initial begin
    logic [4:0] rhist [0:63];
    logic [4:0] gprev;
    int         t;
    int         rb;
    logic [4:0] a_exp;
    logic [4:0] c_exp;
    logic [4:0] rdrive;
    logic       inc;
    logic       wrapped;

    // reset held with activity on the inputs
    w_rst      = 1'b0;
    w_inc      = 1'b1;
    r_ptr_gray = 5'b00110;
    repeat (3) @(posedge w_clk);
    #1;
    check_all_zero("rst_hold");

    w_rst = 1'b1;
    @(posedge w_clk);
    #1;
    chk("rel_waddr", waddr, 1);
    @(posedge w_clk);
    #1;
    chk("rel_waddr2", waddr, 2);

    // asynchronous assertion between edges
    #3;
    w_rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge w_clk);
    #1;
    w_inc      = 1'b0;
    r_ptr_gray = 5'b00000;
    @(posedge w_clk);
    #1;
    w_rst = 1'b1;

    // fill 16 back-to-back writes with read pointer at 0
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk(1'b1, 5'd0, 5'(k), k == 16, k >= 8, 5'(k), 1'b0));
    // writes while full are dropped; overflow sticks
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b1, 5'd0, 5'd16, 1'b1, 1'b1, 5'd16, 1'b1));
    // read pointer -> 4; writes still rejected until wfull drops on 3rd edge
    vecs.push_back(mk(1'b1, 5'b00110, 5'd16, 1'b1, 1'b1, 5'd16, 1'b1));
    vecs.push_back(mk(1'b1, 5'b00110, 5'd16, 1'b1, 1'b1, 5'd16, 1'b1));
    vecs.push_back(mk(1'b1, 5'b00110, 5'd16, 1'b0, 1'b1, 5'd12, 1'b1));
    vecs.push_back(mk(1'b0, 5'b00110, 5'd16, 1'b0, 1'b1, 5'd12, 1'b1));
    // read pointer -> 8: occupancy 8, hfull holds
    vecs.push_back(mk(1'b0, 5'b01100, 5'd16, 1'b0, 1'b1, 5'd12, 1'b1));
    vecs.push_back(mk(1'b0, 5'b01100, 5'd16, 1'b0, 1'b1, 5'd12, 1'b1));
    vecs.push_back(mk(1'b0, 5'b01100, 5'd16, 1'b0, 1'b1, 5'd8,  1'b1));
    // read pointer -> 9: occupancy 7, hfull drops on 3rd edge
    vecs.push_back(mk(1'b0, 5'b01101, 5'd16, 1'b0, 1'b1, 5'd8,  1'b1));
    vecs.push_back(mk(1'b0, 5'b01101, 5'd16, 1'b0, 1'b1, 5'd8,  1'b1));
    vecs.push_back(mk(1'b0, 5'b01101, 5'd16, 1'b0, 1'b0, 5'd7,  1'b1));
    // one write brings occupancy back to 8 on the same edge
    vecs.push_back(mk(1'b1, 5'b01101, 5'd17, 1'b0, 1'b1, 5'd8,  1'b1));

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].inc, vecs[i].rg,
            pack(vecs[i].addr, vecs[i].full, vecs[i].half, vecs[i].cnt, vecs[i].ovf));

    // wrap: 40 writes with read pointer trailing the write count by 2
    w_rst = 1'b0;
    w_inc = 1'b0;
    r_ptr_gray = 5'b00000;
    @(posedge w_clk);
    #1;
    w_rst   = 1'b1;
    t       = 0;
    gprev   = 5'b00000;
    wrapped = 1'b0;
    for (int n = 1; n <= 44; n++) begin
      inc      = (n <= 40);
      rb       = (t >= 2) ? (t - 2) : 0;
      rdrive   = 5'(rb);
      rhist[n] = rdrive;
      if (inc) t++;
      a_exp = 5'(t);
      c_exp = (n >= 3) ? 5'(a_exp - rhist[n-2]) : a_exp;
      apply($sformatf("wrap%0d", n), inc, gray5(rdrive),
            pack(a_exp, c_exp == 5'd16, c_exp >= 5'd8, c_exp, 1'b0));
      if (inc) chk($sformatf("wrap%0d_onebit", n), $countones(w_ptr_gray ^ gprev), 1);
      if (t == 32 && inc) wrapped = (waddr == 5'd0);
      gprev = w_ptr_gray;
    end
    chk("wrap_reached_zero", wrapped, 1);
    chk("wrap_final_wcount", wcount, 2);
    chk("wrap_final_waddr", waddr, 8);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
